// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline: load-use stalls, branch flushes and dmem freezes.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module hazard_stall_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned STAT_W     = 16,
  localparam int unsigned CNT_W     = $clog2(LOAD_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       id_ins,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memrd,
  input  logic                  branch_taken,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_hold,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [STAT_W-1:0]     stall_cycles,
  output logic [STAT_W-1:0]     flush_events
);

  typedef enum logic {RUN, LSTALL} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [6:0]            opc;
  logic [REG_ADDR_W-1:0] rs1, rs2;
  logic                  use_rs1, use_rs2, hit;
  logic                  stall_case, flush_case;
  logic                  unused_ins;

  assign opc        = id_ins[6:0];
  assign rs1        = REG_ADDR_W'(id_ins[19:15]);
  assign rs2        = REG_ADDR_W'(id_ins[24:20]);
  assign unused_ins = ^{id_ins[XLEN-1:25], id_ins[14:7]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign hit = ex_memrd && (ex_rd != '0) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    state_n      = state;
    cnt_n        = cnt;
    stall_case   = 1'b0;
    flush_case   = 1'b0;
    if (rst) begin
      // outputs stay released while reset is held, even if a hazard is visible
    end else if (!dmem_ready) begin
      pipe_hold   = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_n      = RUN;
      cnt_n        = '0;
      flush_case   = 1'b1;
    end else if ((state == LSTALL) || hit) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_case   = 1'b1;
      if (state == LSTALL) begin
        if (cnt == CNT_W'(1)) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end else if (LOAD_LAT > 1) begin
        // the hit cycle itself is the first of LOAD_LAT stall cycles
        state_n = LSTALL;
        cnt_n   = CNT_W'(LOAD_LAT - 1);
      end
    end
  end

  assign stall_cnt = cnt;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_case && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STAT_W'(1);
      if (flush_case && (flush_events != '1))
        flush_events <= flush_events + STAT_W'(1);
    end
  end
`else
  logic unused_stat;
  assign unused_stat  = stall_case ^ flush_case;
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share inputs and are checked
// against a stall-debt reference model, a vector table, directed corner sequences and random stimulus.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_ins;
  logic [4:0]  ex_rd;
  logic        ex_memrd, branch_taken, dmem_ready;

  logic        pcw1, ifw1, fl1, bub1, hold1;
  logic [0:0]  cnt1;
  logic [15:0] sc1_o, fe1_o;
  logic        pcw3, ifw3, fl3, bub3, hold3;
  logic [1:0]  cnt3;
  logic [15:0] sc3_o, fe3_o;

  hazard_stall_ctrl #(.XLEN(32), .REG_ADDR_W(5), .LOAD_LAT(1), .STAT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_ins(id_ins), .ex_rd(ex_rd), .ex_memrd(ex_memrd),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .pc_write(pcw1), .if_id_write(ifw1), .if_id_flush(fl1), .id_ex_bubble(bub1),
    .pipe_hold(hold1), .stall_cnt(cnt1), .stall_cycles(sc1_o), .flush_events(fe1_o));

  hazard_stall_ctrl #(.XLEN(32), .REG_ADDR_W(5), .LOAD_LAT(3), .STAT_W(16)) dut3 (
    .clk(clk), .rst(rst), .id_ins(id_ins), .ex_rd(ex_rd), .ex_memrd(ex_memrd),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .pc_write(pcw3), .if_id_write(ifw3), .if_id_flush(fl3), .id_ex_bubble(bub3),
    .pipe_hold(hold3), .stall_cnt(cnt3), .stall_cycles(sc3_o), .flush_events(fe3_o));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  // model: rem = stall cycles still owed after the current one; sc/fe = statistics
  int rem1, sc1, fe1, rem3, sc3, fe3;

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  rd;
    logic        memrd;
    logic        br;
    logic        rdy;
    logic [4:0]  exp;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
  } vec_t;
  vec_t tab[16];

  localparam logic [4:0] NORM = 5'b11000, STALL = 5'b00010, FLUSH = 5'b11110, FRZ = 5'b00001;

  function automatic logic [31:0] enc(logic [6:0] opc, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
    return {7'b0, r2, r1, 3'b000, rd, opc};
  endfunction

  function automatic bit ref_hit();
    logic [6:0] o;
    bit u1, u2;
    o  = id_ins[6:0];
    u1 = o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    u2 = o inside {7'b0110011, 7'b0100011, 7'b1100011};
    return ex_memrd && ex_rd != 5'd0 &&
           ((u1 && id_ins[19:15] == ex_rd) || (u2 && id_ins[24:20] == ex_rd));
  endfunction

  function automatic logic [63:0] ref_vec(int rem, int sc, int fe);
    logic [4:0] ctl;
    int c;
    c = rst ? 0 : rem;
    if (rst)                      ctl = NORM;
    else if (!dmem_ready)         ctl = FRZ;
    else if (branch_taken)        ctl = FLUSH;
    else if (rem > 0 || ref_hit()) ctl = STALL;
    else                          ctl = NORM;
`ifndef HAZARD_STATS_EN
    sc = 0;
    fe = 0;
`endif
    return {19'b0, ctl, 8'(c), 16'(sc), 16'(fe)};
  endfunction

  function automatic logic [63:0] act1();
    return {19'b0, pcw1, ifw1, fl1, bub1, hold1, 8'(cnt1), sc1_o, fe1_o};
  endfunction

  function automatic logic [63:0] act3();
    return {19'b0, pcw3, ifw3, fl3, bub3, hold3, 8'(cnt3), sc3_o, fe3_o};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic upd(inout int rem, inout int sc, inout int fe, input int lat);
    if (rst) begin
      rem = 0; sc = 0; fe = 0;
    end else if (dmem_ready) begin
      if (branch_taken) begin
        rem = 0;
        if (fe < 65535) fe++;
      end else if (rem > 0 || ref_hit()) begin
        rem = (rem > 0) ? rem - 1 : lat - 1;
        if (sc < 65535) sc++;
      end
    end
  endtask

  task automatic settle(input string tag);
    #1;
    chk({tag, " L1"}, act1(), ref_vec(rem1, sc1, fe1));
    chk({tag, " L3"}, act3(), ref_vec(rem3, sc3, fe3));
  endtask

  task automatic advance();
    @(posedge clk);
    upd(rem1, sc1, fe1, 1);
    upd(rem3, sc3, fe3, 3);
    #1;
  endtask

  task automatic set_in(logic [31:0] ins, logic [4:0] rd, logic memrd, logic br, logic rdy);
    id_ins = ins; ex_rd = rd; ex_memrd = memrd; branch_taken = br; dmem_ready = rdy;
  endtask

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_JAL = 7'b1101111;

  logic [31:0] add_hit, no_hit;
  logic [6:0]  opcs[8];

  initial begin
    add_hit = enc(OP_R, 5'd7, 5'd5, 5'd6);
    no_hit  = enc(OP_R, 5'd7, 5'd1, 5'd2);
    opcs = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR, OP_LUI, OP_JAL};
    tab[0]  = '{add_hit,                         5'd5, 1'b1, 1'b0, 1'b1, STALL};
    tab[1]  = '{enc(OP_R, 5'd7, 5'd6, 5'd5),     5'd5, 1'b1, 1'b0, 1'b1, STALL};
    tab[2]  = '{no_hit,                          5'd5, 1'b1, 1'b0, 1'b1, NORM};
    tab[3]  = '{add_hit,                         5'd5, 1'b0, 1'b0, 1'b1, NORM};
    tab[4]  = '{enc(OP_LUI, 5'd5, 5'd5, 5'd5),   5'd5, 1'b1, 1'b0, 1'b1, NORM};
    tab[5]  = '{enc(OP_R, 5'd7, 5'd0, 5'd0),     5'd0, 1'b1, 1'b0, 1'b1, NORM};
    tab[6]  = '{enc(OP_I, 5'd7, 5'd1, 5'd5),     5'd5, 1'b1, 1'b0, 1'b1, NORM};
    tab[7]  = '{enc(OP_I, 5'd7, 5'd5, 5'd1),     5'd5, 1'b1, 1'b0, 1'b1, STALL};
    tab[8]  = '{enc(OP_ST, 5'd0, 5'd1, 5'd5),    5'd5, 1'b1, 1'b0, 1'b1, STALL};
    tab[9]  = '{enc(OP_BR, 5'd0, 5'd1, 5'd5),    5'd5, 1'b1, 1'b0, 1'b1, STALL};
    tab[10] = '{enc(OP_JALR, 5'd1, 5'd5, 5'd0),  5'd5, 1'b1, 1'b0, 1'b1, STALL};
    tab[11] = '{enc(OP_JALR, 5'd1, 5'd2, 5'd5),  5'd5, 1'b1, 1'b0, 1'b1, NORM};
    tab[12] = '{enc(OP_LD, 5'd8, 5'd5, 5'd0),    5'd5, 1'b1, 1'b0, 1'b1, STALL};
    tab[13] = '{enc(OP_JAL, 5'd1, 5'd5, 5'd5),   5'd5, 1'b1, 1'b0, 1'b1, NORM};
    tab[14] = '{add_hit,                         5'd5, 1'b1, 1'b1, 1'b1, FLUSH};
    tab[15] = '{add_hit,                         5'd5, 1'b1, 1'b1, 1'b0, FRZ};

    rem1 = 0; sc1 = 0; fe1 = 0; rem3 = 0; sc3 = 0; fe3 = 0;
    rst = 1'b0;
    set_in(add_hit, 5'd5, 1'b1, 1'b0, 1'b1);
    #1 rst = 1'b1;
    settle("reset");
    chk("reset forced L1", {pcw1, ifw1, bub1, hold1, fl1, cnt1}, 6'b110000);
    advance();
    rst = 1'b0;

    // vector table, LOAD_LAT=1 never leaves RUN so each row is independent
    foreach (tab[i]) begin
      set_in(tab[i].ins, tab[i].rd, tab[i].memrd, tab[i].br, tab[i].rdy);
      settle($sformatf("tab%0d", i));
      chk($sformatf("tab%0d ctl", i), {59'b0, pcw1, ifw1, fl1, bub1, hold1}, {59'b0, tab[i].exp});
      advance();
    end
    set_in(no_hit, 5'd5, 1'b1, 1'b0, 1'b1);
    settle("drain");
    advance();
    settle("drain");
    advance();

    // LOAD_LAT=3: three stall cycles with stall_cnt 0,2,1
    set_in(add_hit, 5'd5, 1'b1, 1'b0, 1'b1);
    settle("seqA0"); chk("seqA0 L3", {bub3, pcw3, cnt3}, {1'b1, 1'b0, 2'd0}); advance();
    id_ins = no_hit;
    settle("seqA1"); chk("seqA1 L3", {bub3, pcw3, cnt3}, {1'b1, 1'b0, 2'd2}); advance();
    settle("seqA2"); chk("seqA2 L3", {bub3, pcw3, cnt3}, {1'b1, 1'b0, 2'd1}); advance();
    settle("seqA3"); chk("seqA3 L3", {bub3, pcw3, cnt3}, {1'b0, 1'b1, 2'd0}); advance();

    // freeze for two cycles during the second stall cycle
    id_ins = add_hit;
    settle("seqB0"); chk("seqB0 L3", {hold3, bub3, cnt3}, {1'b0, 1'b1, 2'd0}); advance();
    id_ins = no_hit; dmem_ready = 1'b0;
    settle("seqB1"); chk("seqB1 L3", {hold3, pcw3, bub3, cnt3}, {1'b1, 1'b0, 1'b0, 2'd2}); advance();
    settle("seqB2"); chk("seqB2 L3", {hold3, pcw3, bub3, cnt3}, {1'b1, 1'b0, 1'b0, 2'd2}); advance();
    dmem_ready = 1'b1;
    settle("seqB3"); chk("seqB3 L3", {hold3, bub3, cnt3}, {1'b0, 1'b1, 2'd2}); advance();
    settle("seqB4"); chk("seqB4 L3", {hold3, bub3, cnt3}, {1'b0, 1'b1, 2'd1}); advance();
    settle("seqB5"); chk("seqB5 L3", {hold3, bub3, pcw3}, {1'b0, 1'b0, 1'b1}); advance();

    // hit and taken branch together: flush wins, no stall follows
    id_ins = add_hit; branch_taken = 1'b1;
    settle("seqC0"); chk("seqC0 L3", {fl3, bub3, pcw3, ifw3}, 4'b1111); advance();
    id_ins = no_hit; branch_taken = 1'b0;
    settle("seqC1"); chk("seqC1 L3", {fl3, bub3, pcw3, cnt3}, {1'b0, 1'b0, 1'b1, 2'd0}); advance();

    // asynchronous reset between edges while in the middle of a LOAD_LAT=3 stall
    id_ins = add_hit;
    settle("seqD0"); advance();
    settle("seqD1"); chk("seqD1 L3 cnt", 64'(cnt3), 64'd2);
    rst = 1'b1;
    #1;
    rem1 = 0; sc1 = 0; fe1 = 0; rem3 = 0; sc3 = 0; fe3 = 0;
    chk("seqD rst L3", {pcw3, ifw3, bub3, cnt3, sc3_o, fe3_o}, {1'b1, 1'b1, 1'b0, 2'd0, 32'd0});
    chk("seqD rst L1", {pcw1, bub1}, 2'b10);
    #1 rst = 1'b0; id_ins = no_hit;
    settle("seqD2"); chk("seqD2 L3", {bub3, pcw3, cnt3}, {1'b0, 1'b1, 2'd0}); advance();

    // random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      set_in(enc(opcs[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0));
      settle($sformatf("rnd%0d", n));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
